// File: rtl/bitmask_decode_arbiter.sv
// Two-requester round-robin front end sharing one staged bitmask decoder (logical-imm / bitfield).
// Define BITMASK_ARB_PERF_EN to add saturating per-requester grant and stall counters.
module bitmask_decode_arbiter #(
    parameter int unsigned M     = 64,
    parameter int unsigned TAG_W = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_immN,
    input  logic [1:0][5:0]       req_imms,
    input  logic [1:0][5:0]       req_immr,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [1:0][M-1:0]     resp_wmask,
    output logic [1:0][M-1:0]     resp_tmask,
    output logic [1:0][TAG_W-1:0] resp_tag,
    output logic [1:0]            resp_illegal
`ifdef BITMASK_ARB_PERF_EN
    ,
    output logic [1:0][31:0]      perf_grants,
    output logic [1:0][31:0]      perf_stalls
`endif
);

    logic             s1_valid;
    logic             s1_owner;
    logic             s1_immN;
    logic [5:0]       s1_imms;
    logic [5:0]       s1_immr;
    logic [TAG_W-1:0] s1_tag;
    logic             rr_last;

    logic             s1_advance;
    logic             can_grant;
    logic             pick;
    logic [1:0]       grant;
    logic [1:0]       load;

    always_comb begin
        s1_advance = s1_valid && (!resp_valid[s1_owner] || resp_ready[s1_owner]);
        can_grant  = (!s1_valid || s1_advance) && !flush;
        grant      = '0;
        pick       = 1'b0;
        if (can_grant) begin
            case (req_valid)
                2'b01: begin
                    grant = 2'b01;
                    pick  = 1'b0;
                end
                2'b10: begin
                    grant = 2'b10;
                    pick  = 1'b1;
                end
                2'b11: begin
                    pick  = ~rr_last;
                    grant = rr_last ? 2'b01 : 2'b10;
                end
                default: ;
            endcase
        end
        load[0] = s1_advance && !s1_owner;
        load[1] = s1_advance && s1_owner;
    end

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_owner <= 1'b0;
            s1_immN  <= 1'b0;
            s1_imms  <= '0;
            s1_immr  <= '0;
            s1_tag   <= '0;
            rr_last  <= 1'b1;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (|grant) begin
            s1_valid <= 1'b1;
            s1_owner <= pick;
            s1_immN  <= req_immN[pick];
            s1_imms  <= req_imms[pick];
            s1_immr  <= req_immr[pick];
            s1_tag   <= req_tag[pick];
            rr_last  <= pick;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    logic [6:0]   dec_vec;
    logic [2:0]   dec_len;
    logic         dec_none;
    logic [5:0]   levels;
    logic [5:0]   s_val;
    logic [5:0]   r_val;
    logic [5:0]   d_val;
    logic [5:0]   pos;
    logic         dec_illegal;
    logic [M-1:0] dec_wmask;
    logic [M-1:0] dec_tmask;

    // Per-bit form of Replicate(ROR(Ones(S+1),R)) / Replicate(Ones(d+1)); levels doubles as esize-1.
    always_comb begin
        dec_vec  = {s1_immN, ~s1_imms};
        dec_len  = '0;
        dec_none = 1'b1;
        for (int unsigned b = 0; b < 7; b++) begin
            if (dec_vec[b]) begin
                dec_len  = 3'(b);
                dec_none = 1'b0;
            end
        end
        levels      = 6'((7'd1 << dec_len) - 7'd1);
        s_val       = s1_imms & levels;
        r_val       = s1_immr & levels;
        d_val       = (s_val - r_val) & levels;
        dec_illegal = dec_none || (dec_len == 3'd0) || (!s1_owner && (s_val == levels));
        dec_wmask   = '0;
        dec_tmask   = '0;
        pos         = '0;
        for (int unsigned k = 0; k < M; k++) begin
            pos          = 6'(k) & levels;
            dec_wmask[k] = (((pos + r_val) & levels) <= s_val);
            dec_tmask[k] = (pos <= d_val);
        end
        if (dec_illegal) begin
            dec_wmask = '0;
            dec_tmask = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid   <= '0;
            resp_wmask   <= '0;
            resp_tmask   <= '0;
            resp_tag     <= '0;
            resp_illegal <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (flush) begin
                    resp_valid[i] <= 1'b0;
                end else if (load[i]) begin
                    resp_valid[i]   <= 1'b1;
                    resp_wmask[i]   <= dec_wmask;
                    resp_tmask[i]   <= dec_tmask;
                    resp_tag[i]     <= s1_tag;
                    resp_illegal[i] <= dec_illegal;
                end else if (resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef BITMASK_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (req_valid[i] && grant[i] && (perf_grants[i] != '1)) begin
                    perf_grants[i] <= perf_grants[i] + 32'd1;
                end
                if (req_valid[i] && !grant[i] && (perf_stalls[i] != '1)) begin
                    perf_stalls[i] <= perf_stalls[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
